// File: rtl/mem_model_pkg.sv
// -----------------------------------------------------------------------------
// mem_model_pkg
// Shared definitions for the behavioural multi-port memory model:
//   - port_state_e      : per-port request FSM states (IDLE, WAIT, RESP)
//   - HALT_INSN_DEFAULT : instruction word that marks the end of a program
//   - LAT_CNT_W         : width of the per-port latency counter (LATENCY <= 15)
//   - word_out_of_range : true when a byte address selects a word beyond storage
// -----------------------------------------------------------------------------
package mem_model_pkg;

  localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0000_006F;
  localparam int          LAT_CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } port_state_e;

  // The word index is the byte address with its two low bits dropped.
  function automatic logic word_out_of_range(input logic [31:0] addr,
                                             input int unsigned depth_words);
    logic [31:0] word_idx;
    word_idx = {2'b00, addr[31:2]};
    return (word_idx >= 32'(depth_words));
  endfunction

endpackage

// File: rtl/mem_port_fsm.sv
// -----------------------------------------------------------------------------
// mem_port_fsm
// One request port of the memory model. Captures a request in IDLE, waits
// LATENCY-1 cycles in WAIT (skipped when LATENCY is 1), presents a one-cycle
// response in RESP and returns to IDLE. Requester inputs are only looked at in
// IDLE, so anything they do while the port is busy has no effect.
//
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   i_read/i_write : request strobes (both high is reported as an error)
//   i_wmask        : byte enables for writes
//   i_address      : byte address (low two bits ignored)
//   i_wdata        : write data
//   o_resp         : one-cycle completion pulse
//   o_error        : error qualifier, only high together with o_resp
//   o_is_read/o_is_write : captured operation
//   o_word/o_wmask/o_wdata : captured word index, byte enables, write data
// -----------------------------------------------------------------------------
module mem_port_fsm
  import mem_model_pkg::*;
#(
  parameter int LATENCY     = 3,
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_read,
  input  logic          i_write,
  input  logic [3:0]    i_wmask,
  input  logic [31:0]   i_address,
  input  logic [31:0]   i_wdata,
  output logic          o_resp,
  output logic          o_error,
  output logic          o_is_read,
  output logic          o_is_write,
  output logic [AW-1:0] o_word,
  output logic [3:0]    o_wmask,
  output logic [31:0]   o_wdata
);

  // Counter load value: WAIT lasts LATENCY-1 cycles, leaving on a zero count.
  localparam logic [LAT_CNT_W-1:0] WAIT_INIT = LAT_CNT_W'(LATENCY - 2);

  port_state_e          r_state;
  logic [LAT_CNT_W-1:0] r_cnt;
  logic                 r_resp;
  logic                 r_err;
  logic                 r_rd;
  logic                 r_wr;
  logic [AW-1:0]        r_word;
  logic [3:0]           r_wmask;
  logic [31:0]          r_wdata;

  logic                 w_req;
  logic                 w_unused_byte_offset;

  assign w_req = i_read | i_write;
  // Byte offset within the word plays no role in a word-wide memory.
  assign w_unused_byte_offset = ^i_address[1:0];

  // Request FSM: capture in IDLE, count down in WAIT, pulse resp in RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_resp  <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_word  <= '0;
      r_wmask <= 4'h0;
      r_wdata <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_rd    <= i_read;
            r_wr    <= i_write;
            r_word  <= i_address[AW+1:2];
            r_wmask <= i_wmask;
            r_wdata <= i_wdata;
            r_err   <= (i_read & i_write) |
                       word_out_of_range(i_address, DEPTH_WORDS);
            if (LATENCY == 1) begin
              r_state <= RESP;
              r_resp  <= 1'b1;
            end else begin
              r_state <= WAIT;
              r_cnt   <= WAIT_INIT;
              r_resp  <= 1'b0;
            end
          end else begin
            r_resp <= 1'b0;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state <= RESP;
            r_resp  <= 1'b1;
          end else begin
            r_cnt  <= r_cnt - LAT_CNT_W'(1);
            r_resp <= 1'b0;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_resp  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_resp  <= 1'b0;
        end
      endcase
    end
  end

  assign o_resp     = r_resp;
  assign o_error    = r_resp & r_err;
  assign o_is_read  = r_rd;
  assign o_is_write = r_wr;
  assign o_word     = r_word;
  assign o_wmask    = r_wmask;
  assign o_wdata    = r_wdata;

endmodule

// File: rtl/mem_port_model.sv
// -----------------------------------------------------------------------------
// mem_port_model
// Behavioural multi-port memory with fixed request-to-response latency.
// Each port has its own mem_port_fsm; the word storage, read mux, byte-wise
// write merge and the sticky halt / error flags live here.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   read/write  : per-port request strobes
//   wmask       : per-port byte enables
//   address     : per-port byte address
//   wdata       : per-port write data
//   resp        : per-port one-cycle completion pulse
//   rdata       : per-port read data, zero unless resp of a good read
//   error       : per-port error qualifier, zero unless resp
//   halt        : sticky, set when port 0 reads HALT_INSN
//   pmem_error  : sticky OR of all reported errors
//
// Storage is never cleared by reset so a bench can preload r_mem directly.
// -----------------------------------------------------------------------------
module mem_port_model
  import mem_model_pkg::*;
#(
  parameter int          NUM_PORTS   = 2,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 3,
  parameter logic [31:0] HALT_INSN   = HALT_INSN_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        read,
  input  logic [NUM_PORTS-1:0]        write,
  input  logic [NUM_PORTS-1:0][3:0]   wmask,
  input  logic [NUM_PORTS-1:0][31:0]  address,
  input  logic [NUM_PORTS-1:0][31:0]  wdata,
  output logic [NUM_PORTS-1:0]        resp,
  output logic [NUM_PORTS-1:0][31:0]  rdata,
  output logic [NUM_PORTS-1:0]        error,
  output logic                        halt,
  output logic                        pmem_error
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0] r_mem [DEPTH_WORDS];

  logic [NUM_PORTS-1:0]          w_resp;
  logic [NUM_PORTS-1:0]          w_err;
  logic [NUM_PORTS-1:0]          w_is_read;
  logic [NUM_PORTS-1:0]          w_is_write;
  logic [NUM_PORTS-1:0][AW-1:0]  w_word;
  logic [NUM_PORTS-1:0][3:0]     w_wmask;
  logic [NUM_PORTS-1:0][31:0]    w_wdata;
  logic [NUM_PORTS-1:0]          w_rd_ok;
  logic [NUM_PORTS-1:0]          w_wr_commit;

  logic r_halt;
  logic r_pmem_error;

  genvar gp;
  generate
    for (gp = 0; gp < NUM_PORTS; gp++) begin : g_port
      mem_port_fsm #(
        .LATENCY     (LATENCY),
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
      ) u_port (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_read     (read[gp]),
        .i_write    (write[gp]),
        .i_wmask    (wmask[gp]),
        .i_address  (address[gp]),
        .i_wdata    (wdata[gp]),
        .o_resp     (w_resp[gp]),
        .o_error    (w_err[gp]),
        .o_is_read  (w_is_read[gp]),
        .o_is_write (w_is_write[gp]),
        .o_word     (w_word[gp]),
        .o_wmask    (w_wmask[gp]),
        .o_wdata    (w_wdata[gp])
      );
    end
  endgenerate

  assign resp  = w_resp;
  assign error = w_err;

  // Qualify good reads and writes; a write in flight during reset never lands.
  always_comb begin
    w_rd_ok     = '0;
    w_wr_commit = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_rd_ok[p]     = w_resp[p] & w_is_read[p] & ~w_err[p];
      w_wr_commit[p] = w_resp[p] & w_is_write[p] & ~w_err[p] & rst_n;
    end
  end

  // Read mux: storage as it stands during RESP, so a same-cycle write is not seen.
  always_comb begin
    rdata = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_rd_ok[p]) begin
        rdata[p] = r_mem[w_word[p]];
      end else begin
        rdata[p] = 32'h0;
      end
    end
  end

  // Byte-wise write merge; later ports overwrite earlier ones per enabled byte.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wr_commit[p] && w_wmask[p][b]) begin
          r_mem[w_word[p]][8*b +: 8] <= w_wdata[p][8*b +: 8];
        end
      end
    end
  end

  // Sticky status flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_halt       <= 1'b0;
      r_pmem_error <= 1'b0;
    end else begin
      if (|(w_resp & w_err)) begin
        r_pmem_error <= 1'b1;
      end
      if (w_rd_ok[0] && (rdata[0] == HALT_INSN)) begin
        r_halt <= 1'b1;
      end
    end
  end

  assign halt       = r_halt;
  assign pmem_error = r_pmem_error;

endmodule

// File: tb/tb_mem_port_model.sv
// -----------------------------------------------------------------------------
// tb_mem_port_model
// Scoreboard bench: each issued request pushes its description and the cycle
// its response is due into a per-port queue. A monitor on the falling edge pops
// due entries and compares resp/error/rdata against a plain array model of the
// memory, then applies the cycle's writes to the model in port order.
// -----------------------------------------------------------------------------
module tb_mem_port_model;

  localparam int          NP    = 2;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 3;
  localparam logic [31:0] HALT  = 32'h0000_006F;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NP-1:0]        read;
  logic [NP-1:0]        write;
  logic [NP-1:0][3:0]   wmask;
  logic [NP-1:0][31:0]  address;
  logic [NP-1:0][31:0]  wdata;
  logic [NP-1:0]        resp;
  logic [NP-1:0][31:0]  rdata;
  logic [NP-1:0]        error;
  logic                 halt;
  logic                 pmem_error;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  mask;
    int          exp_cyc;
  } item_t;

  item_t       sbq [NP][$];
  logic [31:0] m_mem [DEPTH];
  bit          m_halt;
  bit          m_pmem;
  logic [31:0] last_rdata [NP];
  logic        last_err [NP];

  mem_port_model #(
    .NUM_PORTS   (NP),
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT),
    .HALT_INSN   (HALT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .read       (read),
    .write      (write),
    .wmask      (wmask),
    .address    (address),
    .wdata      (wdata),
    .resp       (resp),
    .rdata      (rdata),
    .error      (error),
    .halt       (halt),
    .pmem_error (pmem_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int p, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s port%0d cycle %0d: got %h expected %h", name, p, cyc, got, exp);
    end
  endtask

  function automatic bit item_err(input item_t it);
    return (it.rd && it.wr) || (it.addr[31:2] >= 30'(DEPTH));
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    dut.r_mem[idx] = v;
    m_mem[idx]     = v;
  endtask

  // Drive one request (called just after a rising edge), hold the op through
  // RESP with scrambled payload, return in the cycle after RESP.
  task automatic issue(input int p, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] m);
    item_t it;
    read[p]    = rd;
    write[p]   = wr;
    address[p] = addr;
    wdata[p]   = wd;
    wmask[p]   = m;
    it = '{rd, wr, addr, wd, m, cyc + LAT};
    sbq[p].push_back(it);
    tick(1);
    address[p] = $urandom;
    wdata[p]   = $urandom;
    wmask[p]   = 4'($urandom);
    tick(LAT);
    read[p]  = 1'b0;
    write[p] = 1'b0;
  endtask

  task automatic rand_port(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      int          kind;
      int          gap;
      logic [31:0] a;
      gap  = $urandom_range(0, 2);
      kind = $urandom_range(0, 99);
      if (gap > 0) tick(gap);
      a = {26'($urandom_range(0, 15)), 2'($urandom)} << 2;
      a = {a[31:2], 2'($urandom)};
      if (kind < 8) begin
        issue(p, 1'b1, 1'b1, a, $urandom, 4'($urandom));
      end else if (kind < 16) begin
        issue(p, kind[0], ~kind[0], $urandom | 32'h0000_1000, $urandom, 4'($urandom));
      end else if (kind < 58) begin
        issue(p, 1'b1, 1'b0, a, $urandom, 4'($urandom));
      end else begin
        issue(p, 1'b0, 1'b1, a, $urandom, 4'($urandom));
      end
    end
  endtask

  task automatic monitor_cycle();
    bit          do_w [NP];
    item_t       wit [NP];
    item_t       it;
    bit          e;
    logic [31:0] exp_rd;
    chk("halt", 0, 32'(halt), 32'(m_halt));
    chk("pmem_error", 0, 32'(pmem_error), 32'(m_pmem));
    for (int p = 0; p < NP; p++) begin
      do_w[p] = 1'b0;
      if (sbq[p].size() > 0 && sbq[p][0].exp_cyc == cyc) begin
        it     = sbq[p].pop_front();
        e      = item_err(it);
        exp_rd = (it.rd && !e) ? m_mem[it.addr[11:2]] : 32'h0;
        chk("resp", p, 32'(resp[p]), 32'd1);
        chk("error", p, 32'(error[p]), 32'(e));
        chk("rdata", p, rdata[p], exp_rd);
        last_rdata[p] = rdata[p];
        last_err[p]   = error[p];
        if (e) m_pmem = 1'b1;
        if (p == 0 && it.rd && !e && exp_rd == HALT) m_halt = 1'b1;
        if (it.wr && !e) begin
          do_w[p] = 1'b1;
          wit[p]  = it;
        end
      end else begin
        chk("resp_idle", p, 32'(resp[p]), 32'd0);
        chk("rdata_idle", p, rdata[p], 32'h0);
        chk("error_idle", p, 32'(error[p]), 32'd0);
      end
    end
    if (rst_n !== 1'b1) begin
      for (int p = 0; p < NP; p++) sbq[p].delete();
      m_halt = 1'b0;
      m_pmem = 1'b0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (do_w[p]) begin
          for (int b = 0; b < 4; b++) begin
            if (wit[p].mask[b]) m_mem[wit[p].addr[11:2]][8*b +: 8] = wit[p].wd[8*b +: 8];
          end
        end
      end
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      monitor_cycle();
    end
  end

  initial begin
    rst_n   = 1'b0;
    read    = '0;
    write   = '0;
    wmask   = '0;
    address = '0;
    wdata   = '0;
    m_halt  = 1'b0;
    m_pmem  = 1'b0;
    for (int i = 0; i < DEPTH; i++) preload(i, $urandom);
    for (int p = 0; p < NP; p++) begin
      last_rdata[p] = 32'h0;
      last_err[p]   = 1'b0;
    end
    tick(3);
    chk("rst_resp", 0, 32'(resp), 32'd0);
    chk("rst_halt", 0, 32'(halt), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Read of a preloaded word through the data port.
    preload(16, 32'hDEADBEEF);
    issue(1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    chk("s_read_data", 1, last_rdata[1], 32'hDEADBEEF);
    chk("s_read_err", 1, 32'(last_err[1]), 32'd0);

    // Partial write with byte enables, then read back.
    issue(1, 1'b0, 1'b1, 32'h0000_0040, 32'h11223344, 4'b0101);
    issue(1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    chk("s_mask_write", 1, last_rdata[1], 32'hDE22BE44);

    // Same-cycle writes from both ports to one word: port 1 wins.
    fork
      issue(0, 1'b0, 1'b1, 32'h0000_0080, 32'hAAAAAAAA, 4'hF);
      issue(1, 1'b0, 1'b1, 32'h0000_0080, 32'h55555555, 4'hF);
    join
    issue(0, 1'b1, 1'b0, 32'h0000_0082, 32'h0, 4'h0);
    chk("s_write_prio", 0, last_rdata[0], 32'h55555555);

    // Out-of-range word and read+write together both report errors.
    issue(1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    chk("s_oor_err", 1, 32'(last_err[1]), 32'd1);
    chk("s_oor_rdata", 1, last_rdata[1], 32'h0);
    issue(0, 1'b1, 1'b1, 32'h0000_0044, 32'hFFFF_FFFF, 4'hF);
    chk("s_rw_err", 0, 32'(last_err[0]), 32'd1);
    tick(2);
    chk("s_pmem_sticky", 0, 32'(pmem_error), 32'd1);

    // Reset during WAIT of a write: dropped, word unchanged, flags cleared.
    write[1]   = 1'b1;
    address[1] = 32'h0000_0040;
    wdata[1]   = 32'hFFFF_FFFF;
    wmask[1]   = 4'hF;
    tick(1);
    write[1] = 1'b0;
    rst_n    = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(LAT + 2);
    chk("s_rst_pmem", 0, 32'(pmem_error), 32'd0);
    chk("s_rst_halt", 0, 32'(halt), 32'd0);
    issue(1, 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0);
    chk("s_rst_word", 1, last_rdata[1], 32'hDE22BE44);

    // Halt only from an instruction-port fetch; sticky until reset.
    preload(48, HALT);
    issue(1, 1'b1, 1'b0, 32'h0000_00C0, 32'h0, 4'h0);
    chk("s_halt_dport", 1, 32'(halt), 32'd0);
    issue(0, 1'b1, 1'b0, 32'h0000_00C2, 32'h0, 4'h0);
    chk("s_halt_set", 0, 32'(halt), 32'd1);
    tick(5);
    chk("s_halt_hold", 0, 32'(halt), 32'd1);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("s_halt_clr", 0, 32'(halt), 32'd0);
    tick(1);

    // Randomized concurrent traffic on both ports.
    fork
      rand_port(0, 120);
      rand_port(1, 120);
    join
    tick(LAT + 2);
    for (int p = 0; p < NP; p++) chk("queue_drained", p, 32'(sbq[p].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
